uart_tx_serializer: RTL

- Transmit-side UART stage, directly downstream of the UART controller's TX FIFO read port.
- Accepts one byte per handshake, then shifts it onto the serial line LSB-first: start bit, 5–8 data bits, optional parity, 1 or 2 stop bits.
- Reports tx_busy_o back to the controller, which gates its FIFO reads on that signal.
- Frame format and baud divisor are supplied by the controller's LCR/DLL/DLM registers and latched at frame start.

---
 rtl/uart_tx_serializer_if.sv | 20 ++
 rtl/uart_tx_serializer.sv | 115 +++++++++++
 2 files changed

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: byte handshake and frame-format bundle between the UART controller and its TX serializer
interface uart_tx_serializer_if;
  logic [7:0]  din_8b;
  logic        din_valid;
  logic        tx_busy;
  logic        tx_done;
  logic [15:0] divisor_16b;
  logic [1:0]  data_len_2b;
  logic        stop_bits;
  logic        parity_en;
  logic [1:0]  parity_mode_2b;
  modport master (
    output din_8b, din_valid, divisor_16b, data_len_2b, stop_bits, parity_en, parity_mode_2b,
    input  tx_busy, tx_done
  );
  modport slave (
    input  din_8b, din_valid, divisor_16b, data_len_2b, stop_bits, parity_en, parity_mode_2b,
    output tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: shifts one byte per handshake onto the serial line, LSB first, with configurable framing
module uart_tx_serializer #(
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic                   clk_50m_i,
  input  logic                   rst_n_i,
  uart_tx_serializer_if.slave    bus,
  output logic                   uart_tx_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, dm1_q, dm1_d, d_eff;
  logic [7:0]  sh_q, sh_d, mask;
  logic [2:0]  bit_q, bit_d, last_q, last_d;
  logic        par_en_q, par_en_d, par_q, par_d, stop2_q, stop2_d;
  logic        tx_q, tx_d, busy_q, busy_d, done_q, done_d, tick, ones;
  assign d_eff = bus.divisor_16b == 16'd0 ? DEFAULT_DIV : bus.divisor_16b == 16'd1 ? 16'd2 : bus.divisor_16b;
  assign mask  = 8'hFF >> (2'd3 - bus.data_len_2b);
  assign ones  = ^(bus.din_8b & mask);
  assign tick  = cnt_q == 16'd0;
  assign uart_tx_o   = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;
  // bit_q counts remaining data bits in DATA and remaining extra stop bits in STOP
  always_comb begin
    state_d  = state_q;
    cnt_d    = state_q == IDLE ? 16'd0 : tick ? dm1_q : cnt_q - 16'd1;
    dm1_d    = dm1_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    last_d   = last_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.din_valid) begin
        state_d  = START;
        cnt_d    = d_eff - 16'd1;
        dm1_d    = d_eff - 16'd1;
        sh_d     = bus.din_8b & mask;
        last_d   = {1'b1, bus.data_len_2b};
        par_en_d = bus.parity_en;
        par_d    = bus.parity_mode_2b[1] ? bus.parity_mode_2b[0] : ones ^ ~bus.parity_mode_2b[0];
        stop2_d  = bus.stop_bits;
        tx_d     = 1'b0;
        busy_d   = 1'b1;
      end
      START: if (tick) begin
        state_d = DATA;
        tx_d    = sh_q[0];
        sh_d    = sh_q >> 1;
        bit_d   = last_q;
      end
      DATA: if (tick) begin
        if (bit_q == 3'd0) begin
          state_d = par_en_q ? PARITY : STOP;
          tx_d    = par_en_q ? par_q : 1'b1;
          bit_d   = {2'b00, stop2_q};
        end else begin
          bit_d = bit_q - 3'd1;
          tx_d  = sh_q[0];
          sh_d  = sh_q >> 1;
        end
      end
      PARITY: if (tick) begin
        state_d = STOP;
        tx_d    = 1'b1;
        bit_d   = {2'b00, stop2_q};
      end
      STOP: if (tick) begin
        if (bit_q == 3'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      dm1_q    <= 16'd0;
      sh_q     <= 8'd0;
      bit_q    <= 3'd0;
      last_q   <= 3'd0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dm1_q    <= dm1_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      last_q   <= last_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
endmodule
